motion_nav_ctrl: RTL and testbench
==================================

Name: motion_nav_ctrl

Overview:
- Clocked motion controller for the robot drive.
- Synchronises and debounces the four magnetic obstacle sensors (front right, front left, rear right, rear left).
- Selects the sensor pair facing the direction of travel and sequences the two drive motors through drive, timed-turn and timed-halt states.
- Sits between the raw sensor and direction-switch pins and the motor driver enables; it also drives the 8 status LEDs.

Parameters:
DEB_CYCLES, 4, consecutive cycles a synchronised sensor must differ from its debounced value before the debounced value updates (range 1..255)
TURN_CYCLES, 16, minimum dwell in a turn state before the sensors are re-evaluated (range 1..65535)
STOP_CYCLES, 8, dwell in HALT before the sensors are re-evaluated (range 1..65535)

Ports:
clk  in  1  system clock; all state changes on the rising edge
rst_n  in  1  asynchronous, active-low reset
run  in  1  1 = motion enabled; 0 = return to IDLE
dir_fwd  in  1  1 = forward travel (use rfs/lfs), 0 = reverse travel (use rrs/lrs)
rfs  in  1  right front sensor, asynchronous; 1 = obstacle
lfs  in  1  left front sensor, asynchronous; 1 = obstacle
rrs  in  1  right rear sensor, asynchronous; 1 = obstacle
lrs  in  1  left rear sensor, asynchronous; 1 = obstacle
motor_l_en  out  1  left motor enable
motor_r_en  out  1  right motor enable
motor_l_rev  out  1  left motor reverse
motor_r_rev  out  1  right motor reverse
leds  out  8  state indicator
blocked  out  1  1 while in HALT

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, all sync flops and debounced values=0, counters=0, dir_lat=1, all motor outputs=0, leds=8'h00, blocked=0.
- Input conditioning:
  - Each sensor passes through a 2-flop synchroniser, then a debouncer.
  - The debounce counter increments on each edge where sync != debounced.
  - When the counter reaches DEB_CYCLES, the debounced value takes the sync value and the counter clears.
  - The counter clears whenever sync == debounced.
  - Pulses shorter than DEB_CYCLES cycles are ignored.
- Pair select: (R,L) = dir_lat ? (rfs_db,lfs_db) : (rrs_db,lrs_db).
- Decision D(R,L): (0,0) -> DRIVE; (1,0) -> TURN_L; (0,1) -> TURN_R; (1,1) -> HALT.
- States and transitions (priority order within each edge):
  1. run=0 -> IDLE from any state.
  2. Not IDLE and dir_fwd != dir_lat -> HALT, timer loaded.
  3. State-specific rules:
     - IDLE: when run=1, latch dir_lat <= dir_fwd and go to D(R,L) evaluated on the newly selected pair in the following cycle. IDLE -> (latch cycle, still IDLE outputs) -> D.
     - DRIVE: each edge go to D(R,L); stay if DRIVE.
     - TURN_L/TURN_R: the timer loads TURN_CYCLES-1 on entry and decrements each edge. At timer=0, go to D(R,L); re-entering the same turn reloads the timer. Sensor changes before expiry are ignored.
     - HALT: the timer loads STOP_CYCLES-1 on entry. At timer=0, go to D(R,L); HALT -> HALT reloads the timer.
- Timer: 16-bit, no wrap; holds at 0.
- Outputs are a registered Moore decode of the state (update on the same edge as the state):
  - IDLE: en=00, leds 8'h00.
  - DRIVE: l_en=r_en=1, leds 8'hFF.
  - TURN_L: r_en=1, l_en=0, leds 8'hF0.
  - TURN_R: l_en=1, r_en=0, leds 8'h0F.
  - HALT: en=00, leds 8'h81, blocked=1.
  - motor_*_rev = ~dir_lat whenever the corresponding en=1, else 0.
- Latency: with run=1 in DRIVE, a raw sensor change held stable changes the outputs after rising edge DEB_CYCLES+3, counting the first edge that samples the new raw value as edge 1 (7 edges at default).
- Reset asserted mid-turn or mid-halt: motors drop to 0 immediately (asynchronous); after release the FSM starts in IDLE.

Test Plan:
- Reset, run=1, dir_fwd=1, all sensors 0 -> IDLE for 2 edges, then DRIVE: en=11, rev=00, leds=FF.
- In DRIVE, rfs=1 held -> after edge 7, TURN_L: en l/r=0/1, leds=F0. rfs released at once -> stays TURN_L exactly 16 cycles, then DRIVE.
- rfs=lfs=1 held -> HALT: leds=81, blocked=1; re-evaluated every 8 cycles, stays HALT. Release both -> DRIVE within 8+7 cycles.
- 3-cycle glitch on lfs (DEB_CYCLES=4) -> no state change; a 4-cycle pulse -> TURN_R, leds=0F.
- DRIVE forward, dir_fwd->0 -> HALT next edge; after 8 cycles with rear sensors clear -> DRIVE with rev=11. Front sensors now ignored (rfs=1 gives no turn).
- run->0 during TURN_L -> IDLE next edge, en=00. Assert rst_n=0 mid-HALT -> outputs 0 without waiting for a clock edge.

Source files
------------

// File: rtl/motion_nav_ctrl.sv
// Drive motion controller: sensor sync/debounce, direction pair select,
// and drive/turn/halt sequencing with registered motor and LED outputs.
module motion_nav_ctrl #(
    parameter int DEB_CYCLES  = 4,
    parameter int TURN_CYCLES = 16,
    parameter int STOP_CYCLES = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    input  logic       dir_fwd,
    input  logic       rfs,
    input  logic       lfs,
    input  logic       rrs,
    input  logic       lrs,
    output logic       motor_l_en,
    output logic       motor_r_en,
    output logic       motor_l_rev,
    output logic       motor_r_rev,
    output logic [7:0] leds,
    output logic       blocked
);

    typedef enum logic [2:0] {
        IDLE,
        DRIVE,
        TURN_L,
        TURN_R,
        HALT
    } state_t;

    localparam logic [7:0]  DEB_LAST = 8'(DEB_CYCLES - 1);
    localparam logic [15:0] TURN_LD  = 16'(TURN_CYCLES - 1);
    localparam logic [15:0] STOP_LD  = 16'(STOP_CYCLES - 1);

    // Sensor vectors are ordered {rfs, lfs, rrs, lrs}
    logic [3:0] s1;
    logic [3:0] s2;
    logic [3:0] db;
    logic [7:0] cnt [4];

    state_t      state;
    state_t      ns;
    state_t      dec;
    logic        dir_lat;
    logic        nd;
    logic        armed;
    logic        na;
    logic [15:0] timer;
    logic [15:0] nt;
    logic        pr;
    logic        pl;
    logic        l_en;
    logic        r_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= '0;
            s2 <= '0;
            db <= '0;
            for (int i = 0; i < 4; i++) cnt[i] <= '0;
        end else begin
            s1 <= {rfs, lfs, rrs, lrs};
            s2 <= s1;
            for (int i = 0; i < 4; i++) begin
                if (s2[i] == db[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == DEB_LAST) begin
                    db[i]  <= s2[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 8'd1;
                end
            end
        end
    end

    assign pr = dir_lat ? db[3] : db[1];
    assign pl = dir_lat ? db[2] : db[0];

    always_comb begin
        dec = HALT;
        unique case ({pr, pl})
            2'b00:   dec = DRIVE;
            2'b10:   dec = TURN_L;
            2'b01:   dec = TURN_R;
            default: dec = HALT;
        endcase
    end

    function automatic logic [15:0] load(input state_t s);
        unique case (s)
            TURN_L, TURN_R: load = TURN_LD;
            HALT:           load = STOP_LD;
            default:        load = '0;
        endcase
    endfunction

    always_comb begin
        ns = state;
        nd = dir_lat;
        na = armed;
        nt = timer;
        if (!run) begin
            ns = IDLE;
            na = 1'b0;
        end else if (state != IDLE && dir_fwd != dir_lat) begin
            // Reversal always passes through a timed halt on the new pair
            ns = HALT;
            nd = dir_fwd;
            nt = STOP_LD;
        end else begin
            unique case (state)
                IDLE: begin
                    if (!armed) begin
                        nd = dir_fwd;
                        na = 1'b1;
                    end else begin
                        ns = dec;
                        na = 1'b0;
                        nt = load(dec);
                    end
                end
                DRIVE: begin
                    ns = dec;
                    nt = load(dec);
                end
                TURN_L, TURN_R, HALT: begin
                    if (timer == '0) begin
                        ns = dec;
                        nt = load(dec);
                    end else begin
                        nt = timer - 16'd1;
                    end
                end
                default: ns = IDLE;
            endcase
        end
    end

    assign l_en = (ns == DRIVE) || (ns == TURN_R);
    assign r_en = (ns == DRIVE) || (ns == TURN_L);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            dir_lat     <= 1'b1;
            armed       <= 1'b0;
            timer       <= '0;
            motor_l_en  <= 1'b0;
            motor_r_en  <= 1'b0;
            motor_l_rev <= 1'b0;
            motor_r_rev <= 1'b0;
            leds        <= 8'h00;
            blocked     <= 1'b0;
        end else begin
            state       <= ns;
            dir_lat     <= nd;
            armed       <= na;
            timer       <= nt;
            motor_l_en  <= l_en;
            motor_r_en  <= r_en;
            motor_l_rev <= l_en & ~nd;
            motor_r_rev <= r_en & ~nd;
            blocked     <= (ns == HALT);
            unique case (ns)
                DRIVE:   leds <= 8'hFF;
                TURN_L:  leds <= 8'hF0;
                TURN_R:  leds <= 8'h0F;
                HALT:    leds <= 8'h81;
                default: leds <= 8'h00;
            endcase
        end
    end

endmodule

// File: tb/tb_motion_nav_ctrl.sv
// Randomised bench for motion_nav_ctrl against a dwell-based reference model.
module tb_motion_nav_ctrl;

    localparam int DEB  = 4;
    localparam int TURN = 16;
    localparam int STOP = 8;

    localparam int M_IDLE  = 0;
    localparam int M_DRIVE = 1;
    localparam int M_TL    = 2;
    localparam int M_TR    = 3;
    localparam int M_HALT  = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       run = 1'b0;
    logic       dir_fwd = 1'b1;
    logic       rfs = 1'b0;
    logic       lfs = 1'b0;
    logic       rrs = 1'b0;
    logic       lrs = 1'b0;
    logic       motor_l_en;
    logic       motor_r_en;
    logic       motor_l_rev;
    logic       motor_r_rev;
    logic [7:0] leds;
    logic       blocked;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    bit [3:0] ms1;
    bit [3:0] ms2;
    bit [3:0] mdb;
    bit [3:0] hist[$];
    int       mst;
    int       mage;
    bit       mdl;
    bit       mpend;

    motion_nav_ctrl #(
        .DEB_CYCLES (DEB),
        .TURN_CYCLES(TURN),
        .STOP_CYCLES(STOP)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .run        (run),
        .dir_fwd    (dir_fwd),
        .rfs        (rfs),
        .lfs        (lfs),
        .rrs        (rrs),
        .lrs        (lrs),
        .motor_l_en (motor_l_en),
        .motor_r_en (motor_r_en),
        .motor_l_rev(motor_l_rev),
        .motor_r_rev(motor_r_rev),
        .leds       (leds),
        .blocked    (blocked)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [12:0] got,
                         input logic [12:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    function automatic logic [12:0] expect_vec();
        bit       le;
        bit       re;
        bit       blk;
        bit [7:0] lv;
        le  = (mst == M_DRIVE) || (mst == M_TR);
        re  = (mst == M_DRIVE) || (mst == M_TL);
        blk = (mst == M_HALT);
        lv  = 8'h00;
        if (mst == M_DRIVE) lv = 8'hFF;
        if (mst == M_TL)    lv = 8'hF0;
        if (mst == M_TR)    lv = 8'h0F;
        if (mst == M_HALT)  lv = 8'h81;
        return {blk, le, re, le & ~mdl, re & ~mdl, lv};
    endfunction

    function automatic logic [12:0] dut_vec();
        return {blocked, motor_l_en, motor_r_en, motor_l_rev, motor_r_rev, leds};
    endfunction

    function automatic int decide(input bit r, input bit l);
        if (!r && !l) return M_DRIVE;
        if (r && !l)  return M_TL;
        if (!r && l)  return M_TR;
        return M_HALT;
    endfunction

    task automatic enter(input int s);
        mst  = s;
        mage = 0;
    endtask

    task automatic model_reset();
        ms1 = '0;
        ms2 = '0;
        mdb = '0;
        hist.delete();
        mst   = M_IDLE;
        mage  = 0;
        mdl   = 1'b1;
        mpend = 1'b0;
    endtask

    task automatic model_edge();
        bit r;
        bit l;
        bit all_diff;
        r = mdl ? mdb[3] : mdb[1];
        l = mdl ? mdb[2] : mdb[0];
        if (!run) begin
            mst   = M_IDLE;
            mpend = 1'b0;
        end else if (mst != M_IDLE && dir_fwd != mdl) begin
            mdl = dir_fwd;
            enter(M_HALT);
        end else begin
            case (mst)
                M_IDLE: begin
                    if (!mpend) begin
                        mdl   = dir_fwd;
                        mpend = 1'b1;
                    end else begin
                        mpend = 1'b0;
                        enter(decide(r, l));
                    end
                end
                M_DRIVE: enter(decide(r, l));
                M_TL, M_TR: begin
                    mage++;
                    if (mage >= TURN) enter(decide(r, l));
                end
                default: begin
                    mage++;
                    if (mage >= STOP) enter(decide(r, l));
                end
            endcase
        end
        // A debounced bit flips once the last DEB synced samples all disagree
        hist.push_back(ms2);
        if (hist.size() > DEB) void'(hist.pop_front());
        if (hist.size() == DEB) begin
            for (int i = 0; i < 4; i++) begin
                all_diff = 1'b1;
                for (int k = 0; k < DEB; k++)
                    if (hist[k][i] == mdb[i]) all_diff = 1'b0;
                if (all_diff) mdb[i] = ~mdb[i];
            end
        end
        ms2 = ms1;
        ms1 = {rfs, lfs, rrs, lrs};
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_edge();
        #1;
        check(tag, dut_vec(), expect_vec());
    endtask

    task automatic ticks(input int n, input string tag);
        for (int i = 0; i < n; i++) tick(tag);
    endtask

    initial begin
        model_reset();
        #3;
        check("reset", dut_vec(), 13'h0000);
        #4;
        rst_n = 1'b1;
        run   = 1'b1;
        ticks(4, "startup");

        rfs = 1'b1;
        ticks(7, "rfs_detect");
        rfs = 1'b0;
        ticks(24, "turn_l_dwell");

        rfs = 1'b1;
        lfs = 1'b1;
        ticks(30, "halt_hold");
        rfs = 1'b0;
        lfs = 1'b0;
        ticks(18, "halt_release");

        lfs = 1'b1;
        ticks(3, "glitch3");
        lfs = 1'b0;
        ticks(10, "glitch3_after");
        lfs = 1'b1;
        ticks(4, "pulse4");
        lfs = 1'b0;
        ticks(24, "turn_r");

        dir_fwd = 1'b0;
        ticks(12, "reverse");
        rfs = 1'b1;
        ticks(12, "front_ignored");
        rfs = 1'b0;

        rrs = 1'b1;
        ticks(8, "rev_turn");
        rrs = 1'b0;
        ticks(3, "rev_turn_hold");
        run = 1'b0;
        ticks(2, "run_off");
        run = 1'b1;
        ticks(5, "run_on");

        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 7) == 0) rfs = ~rfs;
            if ($urandom_range(0, 7) == 0) lfs = ~lfs;
            if ($urandom_range(0, 7) == 0) rrs = ~rrs;
            if ($urandom_range(0, 7) == 0) lrs = ~lrs;
            if ($urandom_range(0, 149) == 0) dir_fwd = ~dir_fwd;
            if (run && $urandom_range(0, 199) == 0) run = 1'b0;
            else if (!run && $urandom_range(0, 3) == 0) run = 1'b1;
            tick("random");
        end

        run     = 1'b1;
        dir_fwd = 1'b0;
        rfs = 1'b0;
        lfs = 1'b0;
        rrs = 1'b1;
        lrs = 1'b1;
        ticks(25, "to_halt");
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", dut_vec(), 13'h0000);
        model_reset();
        ticks(2, "in_reset");
        rrs = 1'b0;
        lrs = 1'b0;
        #2;
        rst_n = 1'b1;
        ticks(30, "after_reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
